// File: rtl/product_divider_pkg.sv
// Shared types for product_divider: FSM state encoding and the bit-counter
// width helper.
package product_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then compare against the divisor and subtract if it fits.
module divider_step #(
  parameter int VW = 2
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW-1:0] o_rem,
  output logic          o_qbit
);

  logic [VW:0]   w_shift;
  logic [VW-1:0] w_diff;
  logic          w_ge;

  // The carry bit w_shift[VW] alone means the shifted value exceeds any
  // VW-bit divisor; the low-bit subtraction is then exact modulo 2**VW.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_ge    = w_shift[VW] || (w_shift[VW-1:0] >= i_divisor);
    w_diff  = w_shift[VW-1:0] - i_divisor;
    o_qbit  = w_ge;
    o_rem   = w_ge ? w_diff : w_shift[VW-1:0];
  end

endmodule

// File: rtl/product_divider.sv
// Sequential restoring divider recovering factor A from product Z = A*B.
// Optional range_err output enabled by defining PRODUCT_DIVIDER_RANGE_CHK_EN.
module product_divider
  import product_divider_pkg::*;
#(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
  ,
  output logic          range_err
`endif
);

  localparam int CW = clog2(DW);

  state_t        r_state, w_state_next;
  logic [DW-1:0] r_dvd, r_quot, w_quot_next;
  logic [VW-1:0] r_dvs, r_rem, w_rem_next;
  logic [CW-1:0] r_cnt;
  logic          w_qbit;

  divider_step #(.VW(VW)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[r_cnt]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_quot_next  = r_quot;
    w_quot_next[r_cnt] = w_qbit;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (divisor == '0) ? DONE : DIV;
      end
      DIV: begin
        if (r_cnt == '0) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
  // A genuine VW x VW product divides exactly with a quotient that fits VW bits.
  logic w_range_bad;
  assign w_range_bad = ((w_quot_next >> VW) != '0) || (w_rem_next != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
      range_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= CW'(DW - 1);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              div_zero  <= 1'b1;
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
              range_err <= 1'b0;
`endif
            end
          end
        end
        DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          if (r_cnt == '0) begin
            quotient  <= w_quot_next;
            remainder <= w_rem_next;
            div_zero  <= 1'b0;
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
            range_err <= w_range_bad;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
          if (out_ready) range_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_divider.sv
// Directed self-checking bench for product_divider (DW=4, VW=2).
module tb_product_divider;

  localparam int DW = 4;
  localparam int VW = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dividend  = '0;
  logic [VW-1:0] divisor   = '0;
  logic          in_ready, out_valid, div_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
  logic          range_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  product_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
    ,
    .range_err (range_err)
`endif
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns edges from presentation to out_valid.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL issue_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || quotient !== 4'd0 || remainder !== 2'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%0b q=%0d r=%0d dz=%0b required 0 0 0 0",
               out_valid, quotient, remainder, div_zero);
    end
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
    n_checks++;
    if (range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_range_err: got %0b required 0", range_err);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] va [3] = '{4'd6, 4'd9, 4'd7};
    logic [VW-1:0] vb [3] = '{2'd2, 2'd3, 2'd3};
    logic [DW-1:0] eq [3] = '{4'd3, 4'd3, 4'd2};
    logic [VW-1:0] er [3] = '{2'd0, 2'd0, 2'd1};
    logic          eg [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], lat);
      n_checks++;
      if (lat !== 5) begin
        n_fail++;
        $display("FAIL basic_latency %0d/%0d: got %0d required 5", va[i], vb[i], lat);
      end
      n_checks++;
      if (quotient !== eq[i] || remainder !== er[i] || div_zero !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_result %0d/%0d: q=%0d r=%0d dz=%0b rdy=%0b required q=%0d r=%0d dz=0 rdy=0",
                 va[i], vb[i], quotient, remainder, div_zero, in_ready, eq[i], er[i]);
      end
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
      n_checks++;
      if (range_err !== eg[i]) begin
        n_fail++;
        $display("FAIL basic_range_err %0d/%0d: got %0b required %0b", va[i], vb[i], range_err, eg[i]);
      end
`else
      if (eg[i] === 1'bx) $display("note: unexpected range table entry");
`endif
      consume();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_consume: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(4'd5, 2'd0, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL dz_latency: got %0d required 1", lat);
    end
    n_checks++;
    if (div_zero !== 1'b1 || quotient !== 4'hF || remainder !== 2'd1) begin
      n_fail++;
      $display("FAIL dz_result: dz=%0b q=%0h r=%0d required dz=1 q=f r=1", div_zero, quotient, remainder);
    end
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
    n_checks++;
    if (range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_range_err: got %0b required 0", range_err);
    end
`endif
    consume();
  endtask

  task automatic test_hold();
    int lat;
    issue(4'd9, 2'd3, lat);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 4'hA;
      divisor  = 2'd1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 4'd3 ||
          remainder !== 2'd0 || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ov=%0b rdy=%0b q=%0d r=%0d dz=%0b required 1 0 3 0 0",
                 c, out_valid, in_ready, quotient, remainder, div_zero);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_consumed_once: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    in_valid = 1'b1;
    dividend = 4'd6;
    divisor  = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || quotient !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset_state: ov=%0b q=%0d rdy=%0b required 0 0 1", out_valid, quotient, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid high %0d cycles required 0", seen);
    end
    issue(4'd15, 2'd1, lat);
    n_checks++;
    if (lat !== 5 || quotient !== 4'd15 || remainder !== 2'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_op: lat=%0d q=%0d r=%0d dz=%0b required 5 15 0 0",
               lat, quotient, remainder, div_zero);
    end
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
    n_checks++;
    if (range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_range_err: got %0b required 1", range_err);
    end
`endif
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, w, exp_lat;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0) begin
          eq = 4'hF; er = 2'(a % 4); edz = 1'b1; exp_lat = 1;
        end else begin
          eq = 4'(a / b); er = 2'(a % b); edz = 1'b0; exp_lat = 5;
        end
        issue(4'(a), 2'(b), lat);
        n_checks++;
        if (lat !== exp_lat || quotient !== eq || remainder !== er || div_zero !== edz) begin
          n_fail++;
          $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d dz=%0b required lat=%0d q=%0d r=%0d dz=%0b",
                   a, b, lat, quotient, remainder, div_zero, exp_lat, eq, er, edz);
        end
`ifdef PRODUCT_DIVIDER_RANGE_CHK_EN
        n_checks++;
        if (range_err !== (b != 0 && (eq >= 4'd4 || er != 2'd0))) begin
          n_fail++;
          $display("FAIL sweep_range %0d/%0d: got %0b", a, b, range_err);
        end
`endif
        w = 0;
        do begin
          out_ready = (w == 19) ? 1'b1 : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          w++;
        end while (!out_ready && w < 20);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep_consume %0d/%0d: ov=%0b rdy=%0b required 0 1", a, b, out_valid, in_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_divider.md
PRODUCT_DIVIDER -- requirements
Module: product_divider

Interface
REQ-001 Parameter DW, default 4: dividend (product) width in bits; legal range 2..16.
REQ-002 Parameter VW, default 2: divisor width in bits; legal range 1..DW.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  dividend/divisor presented.
REQ-006 in_ready  output  1  block accepts an operand pair.
REQ-007 dividend  input  DW  unsigned product Z.
REQ-008 divisor  input  VW  unsigned known factor B.
REQ-009 out_valid  output  1  result held stable.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 quotient  output  DW  unsigned recovered factor A.
REQ-012 remainder  output  VW  unsigned remainder.
REQ-013 div_zero  output  1  divisor was zero.
REQ-014 range_err  output  1  present only with PRODUCT_DIVIDER_RANGE_CHK_EN (see Configuration).

Function
REQ-015 FSM states IDLE, DIV, DONE; single-hot encoding not required.
REQ-016 IDLE: in_ready=1; in_valid=1 registers dividend/divisor, clears working remainder, sets bit counter to DW-1, goes to DIV.
REQ-017 IDLE with in_valid=1 and divisor=0: skip DIV, go to DONE next cycle with quotient all-ones, remainder = dividend[VW-1:0], div_zero=1.
REQ-018 DIV: restoring division, one quotient bit per cycle, MSB first: shift remainder left inserting next dividend bit; if shifted value >= divisor, subtract and set quotient bit, else keep and clear bit.
REQ-019 Working remainder VW+1 bits wide so the shift never loses the carry; final remainder < divisor always.
REQ-020 DIV lasts exactly DW cycles; counter 0 in DIV transitions to DONE.
REQ-021 Latency: acceptance edge to out_valid=1 is DW+1 cycles (1 cycle for divide-by-zero).
REQ-022 DONE: out_valid=1, in_ready=0, outputs stable; leave to IDLE on out_ready=1.
REQ-023 out_valid and in_ready never both 1; no new acceptance in the DONE->IDLE cycle (one bubble, throughput one op per DW+2 cycles).
REQ-024 out_ready=1 while out_valid=1 is held: result consumed exactly once.
REQ-025 in_valid ignored in DIV and DONE; operands are captured, so input changes mid-operation have no effect.
REQ-026 quotient, remainder, div_zero, range_err registered outputs, no combinational input-to-output path.

Reset
REQ-027 rst_n low: state IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_zero=0, range_err=0, counter=0.
REQ-028 Reset during DIV or DONE aborts the operation; pending result discarded, not delivered.

Configuration
REQ-029 Macro PRODUCT_DIVIDER_RANGE_CHK_EN defined: range_err port exists; set in DONE when divisor!=0 and (quotient >= 2**VW or remainder != 0), i.e. dividend is not a valid VW x VW product for this divisor; cleared on leaving DONE.
REQ-030 Macro undefined: range_err port and its logic absent; all other behaviour identical.

Structure
REQ-031 Shared package holds the FSM state typedef (IDLE/DIV/DONE) and the counter width function clog2(DW).
REQ-032 One sub-module, divider_step: combinational shift-compare-subtract for one quotient bit; instantiated once.

Verification
REQ-033 DW=4,VW=2: dividend=6, divisor=2 -> after 5 cycles quotient=3, remainder=0, div_zero=0, range_err=0.
REQ-034 dividend=9, divisor=3 -> quotient=3, remainder=0; dividend=7, divisor=3 -> quotient=2, remainder=1, range_err=1 (macro on).
REQ-035 divisor=0, dividend=5 -> next cycle out_valid=1, div_zero=1, quotient=4'hF, remainder=1.
REQ-036 out_ready held 0 for 10 cycles after out_valid -> outputs unchanged, in_ready=0 throughout; in_valid pulses ignored.
REQ-037 rst_n asserted at cycle 2 of DIV -> out_valid never rises for that operation; next op 15/1 yields quotient=15, range_err=1.
REQ-038 Exhaustive sweep all 16x4 operand pairs, back-to-back, random out_ready -> every result matches integer division model.
